// File: rtl/rat_recovery_ctrl_pkg.sv
// Shared constants and types for the rename-state recovery controller.
//   ARF_DEPTH   number of architectural registers
//   ARF_IDX     architectural register index width
//   PRF_IDX     physical register index width
//   COPY_WIDTH  RRF entries copied into the speculative RAT per cycle
//   rcv_state_t recovery sequencer states
package rat_recovery_ctrl_pkg;

  localparam int ARF_DEPTH  = 32;
  localparam int ARF_IDX    = 5;
  localparam int PRF_IDX    = 6;
  localparam int COPY_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COPY    = 2'd1,
    REBUILD = 2'd2
  } rcv_state_t;

  // Width of the chunk counter; at least one bit so a single-chunk
  // configuration still has a legal counter.
  function automatic int chunk_cnt_w(input int depth, input int cw);
    int n;
    n = $clog2(depth / cw);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/rat_recovery_ctrl_if.sv
// Signal bundle between the recovery controller and its neighbours
// (ROB flush logic, RRF read ports, RAT write ports, free list).
//   master: the recovery controller
//   slave : the surrounding backend (or a testbench standing in for it)
//
// Free-list handshake: fl_rebuild_req is a level held by the master for as
// long as the rebuild is outstanding; the free list answers with a single
// cycle fl_rebuild_ack pulse, which is only honoured while the request is
// high, and the request drops the cycle after the ack.
interface rat_recovery_ctrl_if #(
  parameter int ARF_IDX    = rat_recovery_ctrl_pkg::ARF_IDX,
  parameter int PRF_IDX    = rat_recovery_ctrl_pkg::PRF_IDX,
  parameter int COPY_WIDTH = rat_recovery_ctrl_pkg::COPY_WIDTH
);

  logic                          flush_req;
  logic                          commit_any;
  logic [COPY_WIDTH*ARF_IDX-1:0] rrf_rd_addr;
  logic [COPY_WIDTH*PRF_IDX-1:0] rrf_rd_data;
  logic [COPY_WIDTH-1:0]         rat_wr_en;
  logic [COPY_WIDTH*ARF_IDX-1:0] rat_wr_arch;
  logic [COPY_WIDTH*PRF_IDX-1:0] rat_wr_phy;
  logic                          fl_rebuild_req;
  logic                          fl_rebuild_ack;
  logic                          busy;
  logic                          proto_err;

  modport master (
    input  flush_req, commit_any, rrf_rd_data, fl_rebuild_ack,
    output rrf_rd_addr, rat_wr_en, rat_wr_arch, rat_wr_phy,
           fl_rebuild_req, busy, proto_err
  );

  modport slave (
    output flush_req, commit_any, rrf_rd_data, fl_rebuild_ack,
    input  rrf_rd_addr, rat_wr_en, rat_wr_arch, rat_wr_phy,
           fl_rebuild_req, busy, proto_err
  );

endinterface

// File: rtl/rat_recovery_ctrl.sv
// Rename-state recovery sequencer. After a flush it walks the retirement
// RAT in COPY_WIDTH-entry chunks, writing each committed mapping into the
// speculative RAT in the same cycle it is read, then asks the free list to
// rebuild and waits for its ack. Rename is stalled (busy) throughout.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   bus        rat_recovery_ctrl_if master side (flush, RRF read, RAT
//              write, free-list handshake, busy, proto_err)
//   dbg_state  current sequencer state, for observation only
module rat_recovery_ctrl
  import rat_recovery_ctrl_pkg::*;
#(
  parameter int ARF_DEPTH  = rat_recovery_ctrl_pkg::ARF_DEPTH,
  parameter int ARF_IDX    = rat_recovery_ctrl_pkg::ARF_IDX,
  parameter int PRF_IDX    = rat_recovery_ctrl_pkg::PRF_IDX,
  parameter int COPY_WIDTH = rat_recovery_ctrl_pkg::COPY_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  rat_recovery_ctrl_if.master bus,
  output rcv_state_t          dbg_state
);

  localparam int NCHUNK = ARF_DEPTH / COPY_WIDTH;
  localparam int CNT_W  = chunk_cnt_w(ARF_DEPTH, COPY_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  rcv_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             proto_err_q;

  logic [COPY_WIDTH*ARF_IDX-1:0] addr_v;
  logic [COPY_WIDTH*PRF_IDX-1:0] phy_v;

  // State, chunk counter and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Nothing may commit while the rename state is being rebuilt.
      if (bus.commit_any && (state != IDLE)) proto_err_q <= 1'b1;
    end
  end

  // Next state. A flush outside IDLE is dropped: recovery already restores
  // the committed map and the ROB is empty, so restarting gains nothing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.flush_req) begin
          state_nxt = COPY;
          cnt_nxt   = '0;
        end
      end
      COPY: begin
        if (cnt == LAST_CHUNK) begin
          state_nxt = REBUILD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REBUILD: begin
        if (bus.fl_rebuild_ack) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Copy datapath: lane i handles entry cnt*COPY_WIDTH + i. Buses read as
  // zero outside COPY so idle cycles never carry stale addresses.
  always_comb begin
    addr_v = '0;
    phy_v  = '0;
    if (state == COPY) begin
      for (int i = 0; i < COPY_WIDTH; i++) begin
        addr_v[i*ARF_IDX +: ARF_IDX] = ARF_IDX'(int'(cnt) * COPY_WIDTH + i);
        phy_v[i*PRF_IDX +: PRF_IDX]  = bus.rrf_rd_data[i*PRF_IDX +: PRF_IDX];
      end
    end
  end

  assign bus.rrf_rd_addr    = addr_v;
  assign bus.rat_wr_arch    = addr_v;
  assign bus.rat_wr_phy     = phy_v;
  // Gated by rst so a reset landing mid-copy never commits a partial chunk.
  assign bus.rat_wr_en      = {COPY_WIDTH{(state == COPY) && !rst}};
  assign bus.fl_rebuild_req = (state == REBUILD);
  assign bus.busy           = (state != IDLE);
  assign bus.proto_err      = proto_err_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
module tb_rat_recovery_ctrl;
  import rat_recovery_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int CW4 = 4;
  localparam int CW8 = 8;

  rat_recovery_ctrl_if #(.ARF_IDX(ARF_IDX), .PRF_IDX(PRF_IDX), .COPY_WIDTH(CW4)) bus4();
  rat_recovery_ctrl_if #(.ARF_IDX(ARF_IDX), .PRF_IDX(PRF_IDX), .COPY_WIDTH(CW8)) bus8();
  rcv_state_t st4, st8;

  rat_recovery_ctrl #(.ARF_DEPTH(ARF_DEPTH), .ARF_IDX(ARF_IDX), .PRF_IDX(PRF_IDX),
                      .COPY_WIDTH(CW4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(st4));

  rat_recovery_ctrl #(.ARF_DEPTH(ARF_DEPTH), .ARF_IDX(ARF_IDX), .PRF_IDX(PRF_IDX),
                      .COPY_WIDTH(CW8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .dbg_state(st8));

  // ---------------- RRF and RAT stand-ins ----------------
  logic [PRF_IDX-1:0] rrf [ARF_DEPTH];
  logic [PRF_IDX-1:0] rat_model [ARF_DEPTH];
  logic [CW4*PRF_IDX-1:0] rd4;
  logic [CW8*PRF_IDX-1:0] rd8;

  always_comb begin
    rd4 = '0;
    for (int i = 0; i < CW4; i++)
      rd4[i*PRF_IDX +: PRF_IDX] = rrf[bus4.rrf_rd_addr[i*ARF_IDX +: ARF_IDX]];
  end
  always_comb begin
    rd8 = '0;
    for (int i = 0; i < CW8; i++)
      rd8[i*PRF_IDX +: PRF_IDX] = rrf[bus8.rrf_rd_addr[i*ARF_IDX +: ARF_IDX]];
  end
  assign bus4.rrf_rd_data = rd4;
  assign bus8.rrf_rd_data = rd8;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ARF_DEPTH; k++) rat_model[k] <= '0;
    end else begin
      for (int i = 0; i < CW4; i++)
        if (bus4.rat_wr_en[i])
          rat_model[bus4.rat_wr_arch[i*ARF_IDX +: ARF_IDX]] <= bus4.rat_wr_phy[i*PRF_IDX +: PRF_IDX];
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected lane buses for chunk c of the 4-wide instance: entry c*4+i,
  // whose committed mapping was preloaded as entry+32.
  function automatic logic [CW4*ARF_IDX-1:0] exp_addr4(input int c);
    logic [CW4*ARF_IDX-1:0] r;
    for (int i = 0; i < CW4; i++) r[i*ARF_IDX +: ARF_IDX] = ARF_IDX'(c * 4 + i);
    return r;
  endfunction

  function automatic logic [CW4*PRF_IDX-1:0] exp_phy4(input int c);
    logic [CW4*PRF_IDX-1:0] r;
    for (int i = 0; i < CW4; i++) r[i*PRF_IDX +: PRF_IDX] = PRF_IDX'(c * 4 + i + 32);
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic                   flush;
    logic                   ack;
    rcv_state_t             st;
    logic                   busy;
    logic                   req;
    logic [CW4-1:0]         en;
    logic [CW4*ARF_IDX-1:0] addr;
    logic [CW4*PRF_IDX-1:0] phy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic flush, input logic ack, input rcv_state_t st,
                              input logic busy, input logic req, input logic [CW4-1:0] en,
                              input logic [CW4*ARF_IDX-1:0] addr,
                              input logic [CW4*PRF_IDX-1:0] phy);
    vec_t v;
    v.flush = flush; v.ack = ack; v.st = st; v.busy = busy;
    v.req = req; v.en = en; v.addr = addr; v.phy = phy;
    return v;
  endfunction

  int n;

  initial begin
    // Row r: inputs held during cycle r, outputs expected in that cycle.
    vecs[0] = mk(1'b1, 1'b0, IDLE, 1'b0, 1'b0, 4'h0, '0, '0);
    for (int c = 0; c < 8; c++)
      vecs[1+c] = mk(1'b0, 1'b0, COPY, 1'b1, 1'b0, 4'hF, exp_addr4(c), exp_phy4(c));
    for (int w = 0; w < 5; w++)
      vecs[9+w] = mk(1'b0, 1'b0, REBUILD, 1'b1, 1'b1, 4'h0, '0, '0);
    vecs[14] = mk(1'b0, 1'b1, REBUILD, 1'b1, 1'b1, 4'h0, '0, '0);
    vecs[15] = mk(1'b0, 1'b0, IDLE, 1'b0, 1'b0, 4'h0, '0, '0);

    for (int k = 0; k < ARF_DEPTH; k++) rrf[k] = PRF_IDX'(k + 32);

    rst = 1'b1;
    bus4.flush_req = 1'b0; bus4.commit_any = 1'b0; bus4.fl_rebuild_ack = 1'b0;
    bus8.flush_req = 1'b0; bus8.commit_any = 1'b0; bus8.fl_rebuild_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset values.
    chk("rst_state", 64'(st4), 64'(IDLE));
    chk("rst_busy", 64'(bus4.busy), 64'd0);
    chk("rst_req", 64'(bus4.fl_rebuild_req), 64'd0);
    chk("rst_wr_en", 64'(bus4.rat_wr_en), 64'd0);
    chk("rst_addr", 64'(bus4.rrf_rd_addr), 64'd0);
    chk("rst_arch", 64'(bus4.rat_wr_arch), 64'd0);
    chk("rst_phy", 64'(bus4.rat_wr_phy), 64'd0);
    chk("rst_proto", 64'(bus4.proto_err), 64'd0);
    rst = 1'b0;
    step();

    // Full flush sequence with a 5-cycle delayed ack.
    for (int r = 0; r < 16; r++) begin
      bus4.flush_req = vecs[r].flush;
      bus4.fl_rebuild_ack = vecs[r].ack;
      #1;
      chk($sformatf("v%0d_state", r), 64'(st4), 64'(vecs[r].st));
      chk($sformatf("v%0d_busy", r), 64'(bus4.busy), 64'(vecs[r].busy));
      chk($sformatf("v%0d_req", r), 64'(bus4.fl_rebuild_req), 64'(vecs[r].req));
      chk($sformatf("v%0d_en", r), 64'(bus4.rat_wr_en), 64'(vecs[r].en));
      chk($sformatf("v%0d_addr", r), 64'(bus4.rrf_rd_addr), 64'(vecs[r].addr));
      chk($sformatf("v%0d_arch", r), 64'(bus4.rat_wr_arch), 64'(vecs[r].addr));
      chk($sformatf("v%0d_phy", r), 64'(bus4.rat_wr_phy), 64'(vecs[r].phy));
      step();
    end
    bus4.flush_req = 1'b0;
    bus4.fl_rebuild_ack = 1'b0;

    for (int k = 0; k < ARF_DEPTH; k++)
      chk($sformatf("rat_%0d", k), 64'(rat_model[k]), 64'(k + 32));

    // Second flush during COPY chunk 3 must not restart the walk.
    bus4.flush_req = 1'b1;
    step();
    bus4.flush_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("reflush_state_c%0d", c), 64'(st4), 64'(COPY));
      chk($sformatf("reflush_addr_c%0d", c), 64'(bus4.rrf_rd_addr), 64'(exp_addr4(c)));
      bus4.flush_req = (c == 3);
      step();
    end
    bus4.flush_req = 1'b0;
    chk("reflush_rebuild", 64'(st4), 64'(REBUILD));
    bus4.fl_rebuild_ack = 1'b1;
    step();
    bus4.fl_rebuild_ack = 1'b0;
    chk("reflush_idle", 64'(st4), 64'(IDLE));
    chk("reflush_busy", 64'(bus4.busy), 64'd0);

    // Reset at COPY chunk 5, then restart from address 0.
    bus4.flush_req = 1'b1;
    step();
    bus4.flush_req = 1'b0;
    repeat (5) step();
    chk("rstmid_addr_c5", 64'(bus4.rrf_rd_addr), 64'(exp_addr4(5)));
    rst = 1'b1;
    #1;
    chk("rstmid_wr_en_in_rst", 64'(bus4.rat_wr_en), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rstmid_state", 64'(st4), 64'(IDLE));
    chk("rstmid_busy", 64'(bus4.busy), 64'd0);
    chk("rstmid_wr_en", 64'(bus4.rat_wr_en), 64'd0);
    bus4.flush_req = 1'b1;
    step();
    bus4.flush_req = 1'b0;
    chk("restart_state", 64'(st4), 64'(COPY));
    chk("restart_addr", 64'(bus4.rrf_rd_addr), 64'(exp_addr4(0)));
    repeat (8) step();
    chk("restart_rebuild", 64'(st4), 64'(REBUILD));
    bus4.fl_rebuild_ack = 1'b1;
    step();
    bus4.fl_rebuild_ack = 1'b0;
    chk("restart_idle", 64'(st4), 64'(IDLE));

    // commit_any while busy makes proto_err sticky until reset.
    bus4.flush_req = 1'b1;
    step();
    bus4.flush_req = 1'b0;
    step();
    chk("proto_before", 64'(bus4.proto_err), 64'd0);
    bus4.commit_any = 1'b1;
    step();
    bus4.commit_any = 1'b0;
    chk("proto_set", 64'(bus4.proto_err), 64'd1);
    repeat (6) step();
    chk("proto_fsm_rebuild", 64'(st4), 64'(REBUILD));
    bus4.fl_rebuild_ack = 1'b1;
    step();
    bus4.fl_rebuild_ack = 1'b0;
    repeat (3) step();
    chk("proto_idle_state", 64'(st4), 64'(IDLE));
    chk("proto_sticky", 64'(bus4.proto_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("proto_cleared", 64'(bus4.proto_err), 64'd0);

    // 8-wide instance: a stray ack in IDLE is ignored, then 4 COPY cycles.
    bus8.fl_rebuild_ack = 1'b1;
    step();
    bus8.fl_rebuild_ack = 1'b0;
    chk("cw8_ack_idle_state", 64'(st8), 64'(IDLE));
    chk("cw8_ack_idle_busy", 64'(bus8.busy), 64'd0);
    bus8.flush_req = 1'b1;
    step();
    bus8.flush_req = 1'b0;
    n = 0;
    while (st8 == COPY && n < 20) begin
      chk($sformatf("cw8_addr_c%0d", n), 64'(bus8.rrf_rd_addr[ARF_IDX-1:0]), 64'(n * 8));
      chk($sformatf("cw8_en_c%0d", n), 64'(bus8.rat_wr_en), 64'hFF);
      n++;
      step();
    end
    chk("cw8_copy_cycles", 64'(n), 64'd4);
    chk("cw8_rebuild", 64'(st8), 64'(REBUILD));
    chk("cw8_req", 64'(bus8.fl_rebuild_req), 64'd1);
    bus8.fl_rebuild_ack = 1'b1;
    step();
    bus8.fl_rebuild_ack = 1'b0;
    chk("cw8_idle", 64'(st8), 64'(IDLE));
    chk("cw8_req_drop", 64'(bus8.fl_rebuild_req), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
